// File: rtl/aes_pkg.sv
// Shared AES constants and helpers: S-box, round constants, schedule sizing
// and the key-expansion state encoding.
package aes_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    EXPAND = 1'b1
  } state_t;

  // FIPS-197 S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[2047 - 8 * int'(b) -: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] n);
    logic [7:0] r;
    case (n)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic int nr_of(input int nk);
    return nk + 6;
  endfunction

  function automatic int nw_of(input int nk);
    return 4 * (nk + 7);
  endfunction

endpackage

// File: rtl/aes_sub_word.sv
// Combinational SubWord: S-box applied independently to each byte of a word.
module aes_sub_word
  import aes_pkg::*;
(
  input  logic [31:0] word,
  output logic [31:0] subbed
);

  assign subbed = {sbox(word[31:24]), sbox(word[23:16]),
                   sbox(word[15:8]),  sbox(word[7:0])};

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES key schedule: loads NK key words, then derives one schedule
// word per clock until all NW words are present, then holds with done high.
module aes_key_expand
  import aes_pkg::*;
#(
  parameter  int NK = 4,
  localparam int NR = nr_of(NK),
  localparam int NW = 4 * (NR + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [NK*32-1:0] key_in,
  output logic             busy,
  output logic             done,
  output logic [NW*32-1:0] key_schedule
);

  state_t      state, state_next;
  logic [5:0]  idx;
  logic [2:0]  pos;
  logic [3:0]  grp;
  logic [31:0] prev, back, sub_in, sub_out, temp, new_word;
  logic        last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = EXPAND;
      EXPAND:  if (last)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == EXPAND);
  assign last = (int'(idx) == NW - 1);

  // Fetch w[i-1] and w[i-NK] with constant slices so no index leaves range.
  always_comb begin
    prev = '0;
    back = '0;
    for (int k = 0; k < NW; k++) begin
      if (k == int'(idx) - 1)  prev = key_schedule[NW*32-1-32*k -: 32];
      if (k == int'(idx) - NK) back = key_schedule[NW*32-1-32*k -: 32];
    end
  end

  // One S-box bank serves both the RotWord and the plain SubWord cases.
  assign sub_in = (pos == 3'd0) ? {prev[23:0], prev[31:24]} : prev;

  aes_sub_word u_sub_word (
    .word   (sub_in),
    .subbed (sub_out)
  );

  always_comb begin
    temp = prev;
    if (pos == 3'd0)                 temp = sub_out ^ {rcon(grp), 24'h0};
    else if (NK == 8 && pos == 3'd4) temp = sub_out;
    new_word = back ^ temp;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_schedule <= '0;
      idx          <= '0;
      pos          <= '0;
      grp          <= '0;
      done         <= 1'b0;
    end else if (state == IDLE && start) begin
      key_schedule <= {key_in, {((NW-NK)*32){1'b0}}};
      idx          <= 6'(NK);
      pos          <= '0;
      grp          <= 4'd1;
      done         <= 1'b0;
    end else if (state == EXPAND) begin
      for (int k = NK; k < NW; k++)
        if (k == int'(idx)) key_schedule[NW*32-1-32*k -: 32] <= new_word;
      idx <= idx + 6'd1;
      if (pos == 3'(NK - 1)) begin
        pos <= '0;
        grp <= grp + 4'd1;
      end else begin
        pos <= pos + 3'd1;
      end
      if (last) done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_aes_key_expand.sv
// Self-checking bench for aes_key_expand at NK=4, 6 and 8 against a
// key-schedule model built from GF(2^8) arithmetic.
module tb_aes_key_expand;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start4 = 1'b0, start6 = 1'b0, start8 = 1'b0;
  logic [127:0] key4 = '0;
  logic [191:0] key6 = '0;
  logic [255:0] key8 = '0;
  logic busy4, busy6, busy8, done4, done6, done8;
  logic [44*32-1:0] sched4;
  logic [52*32-1:0] sched6;
  logic [60*32-1:0] sched8;

  int checks = 0;
  int errors = 0;

  logic [7:0]  sbox_m [256];
  logic [31:0] mw [60];

  always #5 clk = ~clk;

  aes_key_expand #(.NK(4)) dut4 (.clk(clk), .rst_n(rst_n), .start(start4), .key_in(key4),
    .busy(busy4), .done(done4), .key_schedule(sched4));
  aes_key_expand #(.NK(6)) dut6 (.clk(clk), .rst_n(rst_n), .start(start6), .key_in(key6),
    .busy(busy6), .done(done6), .key_schedule(sched6));
  aes_key_expand #(.NK(8)) dut8 (.clk(clk), .rst_n(rst_n), .start(start8), .key_in(key8),
    .busy(busy8), .done(done8), .key_schedule(sched8));

  // ---------------- reference model ----------------
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int n = 0; n < 8; n++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic void build_sbox();
    for (int v = 0; v < 256; v++) begin
      logic [7:0] inv = 8'h01;
      logic [7:0] bv = 8'(v);
      if (v == 0) inv = 8'h00;
      else for (int e = 0; e < 254; e++) inv = gf_mul(inv, bv);
      sbox_m[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endfunction

  function automatic logic [31:0] sub_m(input logic [31:0] w);
    return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
  endfunction

  // key is left-aligned in 256 bits
  function automatic void model_expand(input int nk, input logic [255:0] key);
    int nw = 4 * (nk + 7);
    logic [7:0] rc = 8'h01;
    logic [31:0] t;
    for (int i = 0; i < nk; i++) mw[i] = key[255 - 32*i -: 32];
    for (int i = nk; i < nw; i++) begin
      t = mw[i-1];
      if (i % nk == 0) begin
        t = sub_m({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gf_mul(rc, 8'h02);
      end else if (nk == 8 && i % nk == 4) begin
        t = sub_m(t);
      end
      mw[i] = mw[i-nk] ^ t;
    end
  endfunction

  // ---------------- access helpers ----------------
  function automatic logic [31:0] get_word(input int nk, input int i);
    case (nk)
      4:       return sched4[44*32-1-32*i -: 32];
      6:       return sched6[52*32-1-32*i -: 32];
      default: return sched8[60*32-1-32*i -: 32];
    endcase
  endfunction

  function automatic logic get_busy(input int nk);
    return (nk == 4) ? busy4 : (nk == 6) ? busy6 : busy8;
  endfunction

  function automatic logic get_done(input int nk);
    return (nk == 4) ? done4 : (nk == 6) ? done6 : done8;
  endfunction

  function automatic int first_bad(input int nk);
    for (int i = 0; i < 4 * (nk + 7); i++)
      if (get_word(nk, i) !== mw[i]) return i;
    return -1;
  endfunction

  task automatic pulse_start(input int nk, input logic [255:0] key);
    @(negedge clk);
    case (nk)
      4:       begin key4 = key[255:128]; start4 = 1'b1; end
      6:       begin key6 = key[255:64];  start6 = 1'b1; end
      default: begin key8 = key;          start8 = 1'b1; end
    endcase
    @(negedge clk);
    start4 = 1'b0; start6 = 1'b0; start8 = 1'b0;
  endtask

  // Edges until done rises (-1 on timeout); counts cycles with busy low before done.
  task automatic run_to_done(input int nk, output int edges, output int busy_gaps);
    edges = -1;
    busy_gaps = 0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (get_done(nk)) begin
        edges = n;
        break;
      end
      if (!get_busy(nk)) busy_gaps++;
    end
  endtask

  function automatic logic [255:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    #12;
    checks++;
    if ({busy4, busy6, busy8, done4, done6, done8} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 000000", {busy4, busy6, busy8, done4, done6, done8});
    end
    checks++;
    if (sched4 !== '0 || sched6 !== '0 || sched8 !== '0) begin
      errors++;
      $display("FAIL reset_schedule: got nonzero expected zero");
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_fips(input int nk, input logic [255:0] key, input int wi, input logic [31:0] wv,
                           input int wj, input logic [31:0] wv2);
    int edges, gaps, bad;
    model_expand(nk, key);
    pulse_start(nk, key);
    checks++;
    if (get_busy(nk) !== 1'b1 || get_done(nk) !== 1'b0) begin
      errors++;
      $display("FAIL nk%0d_after_start: busy=%b done=%b expected busy=1 done=0", nk, get_busy(nk), get_done(nk));
    end
    run_to_done(nk, edges, gaps);
    checks++;
    if (edges !== 4 * (nk + 7) - nk) begin
      errors++;
      $display("FAIL nk%0d_latency: got %0d edges expected %0d", nk, edges, 4 * (nk + 7) - nk);
    end
    checks++;
    if (gaps !== 0 || get_busy(nk) !== 1'b0) begin
      errors++;
      $display("FAIL nk%0d_busy: got %0d gaps, busy=%b at done expected 0 gaps, busy=0", nk, gaps, get_busy(nk));
    end
    checks++;
    if (get_word(nk, wi) !== wv) begin
      errors++;
      $display("FAIL nk%0d_w%0d: got %h expected %h", nk, wi, get_word(nk, wi), wv);
    end
    checks++;
    if (get_word(nk, wj) !== wv2) begin
      errors++;
      $display("FAIL nk%0d_w%0d: got %h expected %h", nk, wj, get_word(nk, wj), wv2);
    end
    bad = first_bad(nk);
    checks++;
    if (bad != -1) begin
      errors++;
      $display("FAIL nk%0d_schedule: w[%0d] got %h expected %h", nk, bad, get_word(nk, bad), mw[bad]);
    end
  endtask

  task automatic test_round10_nk4();
    checks++;
    if (sched4[44*32-1-1280 -: 128] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
      errors++;
      $display("FAIL nk4_round10: got %h expected d014f9a8c9ee2589e13f0cc8b6630ca6", sched4[44*32-1-1280 -: 128]);
    end
  endtask

  task automatic test_restart_zero_key();
    int edges, gaps;
    logic nz;
    checks++;
    if (done4 !== 1'b1) begin
      errors++;
      $display("FAIL restart_pre_done: got %b expected 1", done4);
    end
    model_expand(4, '0);
    pulse_start(4, '0);
    checks++;
    if (done4 !== 1'b0 || busy4 !== 1'b1) begin
      errors++;
      $display("FAIL restart_flags: done=%b busy=%b expected done=0 busy=1", done4, busy4);
    end
    nz = 1'b0;
    for (int i = 0; i < 44; i++) if (get_word(4, i) !== 32'h0) nz = 1'b1;
    checks++;
    if (nz !== 1'b0) begin
      errors++;
      $display("FAIL restart_cleared: got nonzero words expected all zero");
    end
    run_to_done(4, edges, gaps);
    checks++;
    if (edges !== 40) begin
      errors++;
      $display("FAIL restart_latency: got %0d expected 40", edges);
    end
    checks++;
    if (get_word(4, 43) !== mw[43]) begin
      errors++;
      $display("FAIL restart_w43: got %h expected %h", get_word(4, 43), mw[43]);
    end
    checks++;
    if (sched4[44*32-1-1280 -: 128] !== 128'hb4ef5bcb3e92e21123e951cf6f8f188e) begin
      errors++;
      $display("FAIL restart_round10: got %h expected b4ef5bcb3e92e21123e951cf6f8f188e", sched4[44*32-1-1280 -: 128]);
    end
  endtask

  task automatic test_start_while_busy();
    int edges, gaps, bad;
    logic [255:0] ka, kb;
    ka = rand_key();
    kb = ~ka;
    model_expand(4, ka);
    pulse_start(4, ka);
    repeat (9) @(negedge clk);
    key4 = kb[255:128];
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    run_to_done(4, edges, gaps);
    checks++;
    if (edges + 10 !== 40) begin
      errors++;
      $display("FAIL busy_start_latency: got %0d expected 40", edges + 10);
    end
    bad = first_bad(4);
    checks++;
    if (bad != -1) begin
      errors++;
      $display("FAIL busy_start_schedule: w[%0d] got %h expected %h", bad, get_word(4, bad), mw[bad]);
    end
  endtask

  task automatic test_async_reset();
    int edges, gaps, bad;
    logic [255:0] k;
    pulse_start(4, rand_key());
    repeat (19) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (busy4 !== 1'b0 || done4 !== 1'b0 || sched4 !== '0) begin
      errors++;
      $display("FAIL async_reset: busy=%b done=%b sched_nonzero=%b expected 0 0 0", busy4, done4, sched4 !== '0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    k = rand_key();
    model_expand(4, k);
    pulse_start(4, k);
    run_to_done(4, edges, gaps);
    bad = first_bad(4);
    checks++;
    if (edges !== 40 || bad != -1) begin
      errors++;
      $display("FAIL async_reset_recover: edges %0d first bad word %0d expected 40 and -1", edges, bad);
    end
  endtask

  task automatic test_random_keys();
    int edges, gaps, bad;
    int nks [3] = '{4, 6, 8};
    logic [255:0] k;
    for (int r = 0; r < 3; r++) begin
      foreach (nks[j]) begin
        k = rand_key();
        model_expand(nks[j], k);
        pulse_start(nks[j], k);
        run_to_done(nks[j], edges, gaps);
        bad = first_bad(nks[j]);
        checks++;
        if (edges !== 4 * (nks[j] + 7) - nks[j] || bad != -1) begin
          errors++;
          $display("FAIL random_nk%0d: edges %0d first bad word %0d expected %0d and -1",
                   nks[j], edges, bad, 4 * (nks[j] + 7) - nks[j]);
        end
      end
    end
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_fips(4, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4, 32'ha0fafe17, 43, 32'hb6630ca6);
    test_round10_nk4();
    test_restart_zero_key();
    test_fips(6, {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0},
              6, 32'hfe0c91f7, 51, 32'h01002202);
    test_fips(8, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4,
              8, 32'h9ba35411, 59, 32'h706c631e);
    test_start_while_busy();
    test_async_reset();
    test_random_keys();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
